// File: rtl/q_8_34f_pkg.sv
// Shared constants and controller state encoding for the ones pattern generator.
// Pure declarations; no logic, no latency, no flow control.
package q_8_34f_pkg;

    localparam int data_size = 8;
    localparam int r2_size   = $clog2(data_size) + 1;

    typedef enum logic [0:0] {
        S_idle = 1'b0,
        S_1    = 1'b1
    } state_t;

endpackage

// File: rtl/ones_pattern_ctrl.sv
// Controller for the ones pattern generator: sequences load, shift and decrement.
// Latency: one load cycle, then one shift per requested one, then one exit cycle.
// Backpressure: none; start is only honoured while idle (rdy high).
module ones_pattern_ctrl
    import q_8_34f_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic zero,
    output logic load_regs,
    output logic decr_r2,
    output logic shift,
    output logic done,
    output logic rdy
);

    state_t state_q;
    state_t state_d;
    logic   Q_out;
    logic   q_out_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_idle;
            Q_out   <= 1'b0;
        end else begin
            state_q <= state_d;
            Q_out   <= q_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_regs = 1'b0;
        decr_r2   = 1'b0;
        shift     = 1'b0;
        q_out_d   = 1'b0;
        case (state_q)
            S_idle: begin
                if (start) begin
                    load_regs = 1'b1;
                    state_d   = S_1;
                end
            end
            S_1: begin
                if (zero) begin
                    // Flag the exit so done is a pure register output in the idle cycle.
                    state_d = S_idle;
                    q_out_d = 1'b1;
                end else begin
                    shift   = 1'b1;
                    decr_r2 = 1'b1;
                end
            end
            default: state_d = S_idle;
        endcase
    end

    assign rdy  = (state_q == S_idle);
    assign done = Q_out;

endmodule

// File: rtl/ones_pattern_gen.sv
// Builds a data_size-bit word holding cnt_in ones, packed at the LSB or MSB end.
// Latency: k+1 cycles after the load edge for saturated count k; rdy high when idle.
// Backpressure: start/cnt_in ignored while busy; requests above data_size saturate and set ovf.
module ones_pattern_gen
    import q_8_34f_pkg::*;
#(
    parameter int data_size = q_8_34f_pkg::data_size,
    parameter int r2_size   = $clog2(data_size) + 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [r2_size-1:0]   cnt_in,
    output logic [data_size-1:0] data_out,
    output logic                 rdy,
    output logic                 done,
    output logic                 ovf
);

    localparam logic [r2_size-1:0] MAX_CNT = r2_size'(data_size);

    logic [data_size-1:0] r1_q, r1_d;
    logic [r2_size-1:0]   r2_q, r2_d;
    logic                 ovf_q, ovf_d;
    logic [data_size-1:0] r1_shifted;
    logic                 over;
    logic                 zero;
    logic                 load_regs;
    logic                 decr_r2;
    logic                 shift;

    ones_pattern_ctrl controller (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .zero      (zero),
        .load_regs (load_regs),
        .decr_r2   (decr_r2),
        .shift     (shift),
        .done      (done),
        .rdy       (rdy)
    );

    assign zero = (r2_q == '0);
    assign over = (cnt_in > MAX_CNT);

    // Saturation bounds the shift count to data_size, so no one is ever pushed out.
    assign r1_shifted = MSB_FIRST ? {1'b1, r1_q[data_size-1:1]}
                                  : {r1_q[data_size-2:0], 1'b1};

    always_comb begin
        r1_d  = r1_q;
        r2_d  = r2_q;
        ovf_d = ovf_q;
        if (load_regs) begin
            r1_d  = '0;
            r2_d  = over ? MAX_CNT : cnt_in;
            ovf_d = over;
        end else begin
            if (shift) begin
                r1_d = r1_shifted;
            end
            if (decr_r2) begin
                r2_d = r2_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q  <= '0;
            r2_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            ovf_q <= ovf_d;
        end
    end

    assign data_out = r1_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: LSB-packed and MSB-packed instances driven in lockstep,
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_ones_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cnt_in;
    logic [7:0] dl, dm;
    logic       rdy_l, rdy_m, done_l, done_m, ovf_l, ovf_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ones_pattern_gen #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .cnt_in(cnt_in),
        .data_out(dl), .rdy(rdy_l), .done(done_l), .ovf(ovf_l)
    );

    ones_pattern_gen #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .cnt_in(cnt_in),
        .data_out(dm), .rdy(rdy_m), .done(done_m), .ovf(ovf_m)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lsb_pat(input int k);
        logic [8:0] t;
        t = (9'd1 << k) - 9'd1;
        return t[7:0];
    endfunction

    function automatic logic [7:0] msb_pat(input int k);
        return ~lsb_pat(8 - k);
    endfunction

    // Transaction model: a request of k ones keeps the block busy for k+1 cycles,
    // then presents the finished pattern with a one-cycle done.
    int         m_left = 0;
    logic [7:0] m_dl = 8'h00, m_dm = 8'h00, p_l = 8'h00, p_m = 8'h00;
    logic       m_ovf = 1'b0, m_done = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        automatic int k;
        if (rst) begin
            m_left = 0; m_dl = 8'h00; m_dm = 8'h00; m_ovf = 1'b0; m_done = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                k      = (int'(cnt_in) > 8) ? 8 : int'(cnt_in);
                m_ovf  = (int'(cnt_in) > 8);
                p_l    = lsb_pat(k);
                p_m    = msb_pat(k);
                m_left = k + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_dl = p_l; m_dm = p_m; m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rdy_l",  rdy_l,  m_left == 0);
            chk("cyc_rdy_m",  rdy_m,  m_left == 0);
            chk("cyc_done_l", done_l, m_done);
            chk("cyc_done_m", done_m, m_done);
            chk("cyc_ovf_l",  ovf_l,  m_ovf);
            chk("cyc_ovf_m",  ovf_m,  m_ovf);
            if (m_left == 0) begin
                chk("cyc_data_l", dl, m_dl);
                chk("cyc_data_m", dm, m_dm);
            end
        end
    end

    // Called at a negedge while idle; returns at the negedge where rdy is back.
    task automatic run(input logic [3:0] c, output int low);
        start  = 1'b1;
        cnt_in = c;
        @(negedge clk);
        start = 1'b0;
        low   = 0;
        for (int i = 0; i < 40; i++) begin
            if (rdy_l) break;
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int low;
        int got;
        rst    = 1'b1;
        start  = 1'b1;
        cnt_in = 4'd5;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("t1_rdy",  rdy_l,  1'b1);
        chk("t1_data", dl,     8'h00);
        chk("t1_ovf",  ovf_l,  1'b0);
        chk("t1_done", done_l, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("t1_no_load", rdy_l, 1'b1);

        run(4'd3, low);
        chk("t2_low",    low,    4);
        chk("t2_data_l", dl,     8'b0000_0111);
        chk("t2_data_m", dm,     8'b1110_0000);
        chk("t2_done",   done_l, 1'b1);
        chk("t2_ovf",    ovf_l,  1'b0);
        @(negedge clk);
        chk("t2_done_once", done_l, 1'b0);
        chk("t2_hold",      dl,     8'h07);

        run(4'd0, low);
        chk("t3_low0",  low, 1);
        chk("t3_data0", dl,  8'h00);
        run(4'd8, low);
        chk("t3_low8",    low, 9);
        chk("t3_data8_l", dl,  8'hFF);
        chk("t3_data8_m", dm,  8'hFF);

        run(4'd12, low);
        chk("t4_low12",  low,   9);
        chk("t4_data12", dl,    8'hFF);
        chk("t4_ovf12",  ovf_l, 1'b1);
        run(4'd2, low);
        chk("t4_data2_l", dl,    8'h03);
        chk("t4_data2_m", dm,    8'hC0);
        chk("t4_ovf2",    ovf_l, 1'b0);

        start  = 1'b1;
        cnt_in = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rdy",  rdy_l,  1'b1);
        chk("t5_data", dl,     8'h00);
        chk("t5_done", done_l, 1'b0);
        @(negedge clk);
        chk("t5_no_done", done_l, 1'b0);

        start = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            cnt_in = 4'(c);
            got = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (i == 0) chk("t6_spacing", rdy_l, 1'b0);
                if (done_l) begin
                    got = 1;
                    break;
                end
            end
            chk("t6_done_seen", got, 1);
            chk("t6_loop_l", $countones(dl), c);
            chk("t6_loop_m", $countones(dm), c);
            chk("t6_msb_pack", dm, msb_pat(c));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_final_l", dl, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
